// File: rtl/pythag_pkg.sv
// Shared types and constants for the inverse-Pythagoras sequencer.
package pythag_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMulC,
    StMulA,
    StSub,
    StRoot,
    StDone
  } state_e;

  localparam int unsigned DefaultW = 8;
  localparam int unsigned MulCyc   = DefaultW;
  localparam int unsigned RootCyc  = DefaultW;
  localparam int unsigned Latency  = 2 * MulCyc + RootCyc + 1;

endpackage

// File: rtl/pythag_leg_seq_if.sv
// Start/done request bus between a requester and pythag_leg_seq.
interface pythag_leg_seq_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] hyp;
  logic [W-1:0] leg;
  logic [W-1:0] leg_out;
  logic         busy;
  logic         done;
  logic         err;

  modport master (output start, hyp, leg, input leg_out, busy, done, err);
  modport slave  (input start, hyp, leg, output leg_out, busy, done, err);
endinterface

// File: rtl/pythag_isqrt.sv
// Restoring digit-by-digit square root, one 2-bit digit pair per step, MSB first.
// root/rem present the result of the step being applied this cycle.
module pythag_isqrt #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [2*W-1:0] rad,
  output logic [W-1:0]   root,
  output logic [W:0]     rem
);

  logic [2*W-1:0] x_q;
  logic [W:0]     rem_q;
  logic [W-2:0]   root_q;
  logic [W+2:0]   part;
  logic [W+2:0]   trial;
  logic           fits;

  always_comb begin
    part  = {rem_q, x_q[2*W-1 -: 2]};
    trial = {2'b00, root_q, 2'b01};
    fits  = (part >= trial);
    root  = {root_q, fits};
    // The true remainder never exceeds 2*root, so the low W+1 bits are exact.
    rem   = fits ? (part[W:0] - trial[W:0]) : part[W:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else if (load) begin
      x_q    <= rad;
      rem_q  <= '0;
      root_q <= '0;
    end else if (step) begin
      x_q    <= {x_q[2*W-3:0], 2'b00};
      rem_q  <= rem;
      root_q <= root[W-2:0];
    end
  end

endmodule

// File: rtl/pythag_leg_seq.sv
// Sequential leg_out = floor(sqrt(hyp^2 - leg^2)) with a shared shift-add multiplier.
// Define PYTHAG_ROUND_EN to round the result to nearest instead of flooring.
module pythag_leg_seq
  import pythag_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input logic             clk,
  input logic             rst,
  input logic             ena,
  pythag_leg_seq_if.slave bus
);

  localparam int unsigned CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   c_q, c_d, a_q, a_d;
  logic [2*W-1:0] acc_q, acc_d, csq_q, csq_d;
  logic           err_n_q, err_n_d;
  logic [W-1:0]   leg_out_q, leg_out_d;
  logic           err_q, err_d, done_q, done_d, busy_q, busy_d;

  logic [W-1:0]   mul_op, root, result;
  logic [2*W-1:0] addend, acc_sum, diff;
  logic [W:0]     rem;
  logic           last, rt_load, rt_step;

  assign mul_op  = (state_q == StMulA) ? a_q : c_q;
  assign addend  = mul_op[cnt_q] ? ({{W{1'b0}}, mul_op} << cnt_q) : '0;
  assign acc_sum = acc_q + addend;
  // Error path feeds a zero radicand so latency stays fixed and the root is 0.
  assign diff    = (csq_q >= acc_q) ? (csq_q - acc_q) : '0;
  assign last    = (cnt_q == LastCnt);

  pythag_isqrt #(
    .W(W)
  ) u_isqrt (
    .clk (clk),
    .rst (rst),
    .load(rt_load),
    .step(rt_step),
    .rad (diff),
    .root(root),
    .rem (rem)
  );

`ifdef PYTHAG_ROUND_EN
  always_comb begin
    result = root;
    if ((rem > {1'b0, root}) && (root != '1)) result = root + 1'b1;
  end
`else
  logic unused_rem;
  assign unused_rem = ^rem;
  assign result     = root;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    a_d       = a_q;
    acc_d     = acc_q;
    csq_d     = csq_q;
    err_n_d   = err_n_q;
    leg_out_d = leg_out_q;
    err_d     = err_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    rt_load   = 1'b0;
    rt_step   = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (bus.start) begin
          c_d     = bus.hyp;
          a_d     = bus.leg;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = StMulC;
        end
      end
      StMulC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          csq_d   = acc_sum;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMulA;
        end
      end
      StMulA: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d   = '0;
          state_d = StSub;
        end
      end
      StSub: begin
        err_n_d = (csq_q < acc_q);
        rt_load = ena;
        state_d = StRoot;
      end
      StRoot: begin
        rt_step = ena;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          cnt_d     = '0;
          leg_out_d = result;
          err_d     = err_n_q;
          done_d    = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      c_q       <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      csq_q     <= '0;
      err_n_q   <= 1'b0;
      leg_out_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      csq_q     <= csq_d;
      err_n_q   <= err_n_d;
      leg_out_q <= leg_out_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.leg_out = leg_out_q;
  assign bus.err     = err_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_pythag_leg_seq.sv
// Self-checking bench for pythag_leg_seq: directed cases plus randomized traffic vs a model.
module tb_pythag_leg_seq;

  localparam int W   = 8;
  localparam int Lat = 25;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  pythag_leg_seq_if #(.W(W)) bus ();

  pythag_leg_seq #(
    .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: transaction-level, driven by the count of enabled cycles since accept.
  logic         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_leg  = '0;
  logic [W:0]   p_res  = '0;
  int           m_cnt  = 0;
  logic         cmp_en = 1'b0;

  // Returns {err, leg_out} from plain integer arithmetic.
  function automatic logic [W:0] ref_leg(input int h, input int l);
    int d, r;
    if (l > h) return {1'b1, {W{1'b0}}};
    d = h * h - l * l;
    r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
`ifdef PYTHAG_ROUND_EN
    if ((d - r * r > r) && (r < (1 << W) - 1)) r++;
`endif
    return {1'b0, r[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_leg  <= '0;
      m_cnt  <= 0;
      cmp_en <= 1'b1;
    end else if (ena) begin
      if (m_busy) begin
        m_cnt  <= m_cnt + 1;
        m_done <= (m_cnt + 1 == Lat);
        if (m_cnt + 1 == Lat) begin
          m_leg <= p_res[W-1:0];
          m_err <= p_res[W];
        end
        if (m_cnt + 1 == Lat + 1) m_busy <= 1'b0;
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        p_res  <= ref_leg(int'(bus.hyp), int'(bus.leg));
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle", {21'd0, bus.busy, bus.done, bus.err, bus.leg_out},
            {21'd0, m_busy, m_done, m_err, m_leg});
  end

  task automatic run_op(input int h, input int l, input int ena_at, input int ena_len,
                        input int again_at, input int rst_at, output int lat, output int ndone,
                        output int nbusy, output logic [W-1:0] leg_o, output logic err_o);
    @(negedge clk);
    rst       = 1'b0;
    ena       = 1'b1;
    bus.hyp   = W'(h);
    bus.leg   = W'(l);
    bus.start = 1'b1;
    lat   = -1;
    ndone = 0;
    nbusy = 0;
    leg_o = '0;
    err_o = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin
          lat   = c - 1;
          leg_o = bus.leg_out;
          err_o = bus.err;
        end
      end
      bus.start = (c == again_at);
      bus.hyp   = W'($urandom);
      bus.leg   = W'($urandom);
      ena       = !(ena_at > 0 && c >= ena_at && c < ena_at + ena_len);
      rst       = (c == rst_at);
    end
  endtask

  int           lat, nd, nb, first, second;
  logic [W-1:0] lo;
  logic         eo;

  initial begin
    rst       = 1'b1;
    ena       = 1'b1;
    bus.start = 1'b0;
    bus.hyp   = '0;
    bus.leg   = '0;
    repeat (3) @(negedge clk);
    check("reset", {bus.busy, bus.done, bus.err, bus.leg_out}, 0);

    run_op(5, 3, 0, 0, 0, 0, lat, nd, nb, lo, eo);
    check("5_3_lat", lat, Lat);
    check("5_3_busy", nb, 26);
    check("5_3_leg", lo, 4);
    check("5_3_err", eo, 0);

    run_op(255, 0, 0, 0, 0, 0, lat, nd, nb, lo, eo);
    check("255_0_leg", lo, 255);
    run_op(6, 1, 0, 0, 0, 0, lat, nd, nb, lo, eo);
`ifdef PYTHAG_ROUND_EN
    check("6_1_leg", lo, 6);
`else
    check("6_1_leg", lo, 5);
`endif

    run_op(3, 5, 0, 0, 0, 0, lat, nd, nb, lo, eo);
    check("3_5_err", eo, 1);
    check("3_5_leg", lo, 0);
    check("3_5_lat", lat, Lat);
    run_op(13, 12, 0, 0, 0, 0, lat, nd, nb, lo, eo);
    check("13_12_leg", lo, 5);
    check("13_12_err", eo, 0);

    run_op(10, 6, 10, 4, 5, 0, lat, nd, nb, lo, eo);
    check("ena_lat", lat, Lat + 4);
    check("ena_leg", lo, 8);
    check("ena_ndone", nd, 1);

    run_op(10, 6, 0, 0, 0, 12, lat, nd, nb, lo, eo);
    check("rst_ndone", nd, 0);
    check("rst_outs", {bus.busy, bus.done, bus.err, bus.leg_out}, 0);
    run_op(10, 8, 0, 0, 0, 0, lat, nd, nb, lo, eo);
    check("10_8_leg", lo, 6);

    // start held high: back-to-back issue at the minimum interval
    @(negedge clk);
    bus.hyp   = 8'd5;
    bus.leg   = 8'd4;
    bus.start = 1'b1;
    first  = -1;
    second = -1;
    nd     = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        check("hold_leg", bus.leg_out, 3);
        if (first < 0) first = c;
        else second = c;
      end
    end
    bus.start = 1'b0;
    check("hold_ndone", nd, 2);
    check("hold_gap", second - first, 27);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 699) == 0);
      ena       = ($urandom_range(0, 4) != 0);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.hyp   = W'($urandom);
      bus.leg   = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                              : W'($urandom_range(0, int'(bus.hyp)));
    end
    @(negedge clk);
    rst       = 1'b0;
    ena       = 1'b1;
    bus.start = 1'b0;
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pythag_leg_seq.md
# pythag_leg_seq

Sequential inverse-Pythagoras unit: given a hypotenuse `hyp` and one leg `leg`, computes the other leg `leg_out = floor(sqrt(hyp² − leg²))`. It is the counterpart of the existing combinational magnitude block, which computes the hypotenuse from two legs. It is a multi-cycle, area-lean datapath with one shift-add multiplier and one digit-by-digit root, sequenced by an FSM behind a start/done handshake. The block sits beside the magnitude block under the Tiny Tapeout top; the top wrapper maps pins.

## Interface
- `W`, default 8: operand and result width. Internal square and difference registers are 2W bits.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  global enable. While low, all state holds, including the FSM, counters and outputs.
- `start`  in  1  request. Sampled only in IDLE with `ena`=1.
- `hyp`  in  W  hypotenuse c. Captured on the accepting edge.
- `leg`  in  W  known leg a. Captured on the accepting edge.
- `leg_out`  out  W  result b. Registered; holds until the next DONE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  valid with `done`, held with `leg_out`. Set when leg > hyp.

## Operation
- Reset values: `leg_out`=0, `busy`=0, `done`=0, `err`=0, FSM=IDLE, internal registers=0.
- FSM states, traversed in this order: IDLE → MUL_C → MUL_A → SUB → ROOT → DONE → IDLE.
- **IDLE**
  - If `start`=1 and `ena`=1: latch `hyp` and `leg`, clear the bit counter, go to MUL_C.
- **MUL_C**
  - 8 edges, one bit per edge, LSB first: `acc += (c << k)` if `c[k]`.
  - Gives `csq` = c², 2W bits.
- **MUL_A**
  - Same procedure on a, giving `asq`, using the same adder.
- **SUB** (1 edge)
  - If `csq` ≥ `asq`: `diff = csq − asq`, `err_n`=0.
  - Otherwise: `diff`=0, `err_n`=1.
- **ROOT**
  - W edges of restoring digit-by-digit square root, MSB first, 2 bits of `diff` per edge.
  - Uses shift and subtract only; no multiplier.
  - Produces root `r` and remainder `rem = diff − r²`.
- **ROOT exit**
  - On the final ROOT edge: register `leg_out` (r, or the rounded value, see Configuration) and `err`, then enter DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- The error path runs the full sequence with `diff`=0. Latency is therefore fixed regardless of operands, and the error case yields `leg_out`=0.
- `start` is ignored while `busy`=1; requests are not queued.
- `start` held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- `rst` mid-operation: return to IDLE the next edge and clear all outputs. No `done` is produced.
- Operand changes after acceptance have no effect.

## Timing
- Accept edge t0. States after t0: MUL_C for t1–t8, MUL_A for t9–t16, SUB at t17, ROOT for t18–t25.
- `done`, `leg_out` and `err` are valid in the cycle after t25, i.e. a latency of 25 enabled cycles from acceptance (2W+W+1 in general).
- Back in IDLE after t26. Minimum issue interval is 27 cycles.
- Every cycle with `ena`=0 extends the latency by exactly 1 and holds `done` if it is asserted.
- All outputs come directly from flops. There are no combinational input-to-output paths.

## Configuration
- `PYTHAG_ROUND_EN`
  - **Defined:** round to nearest. `leg_out = r + 1` when `rem > r`, otherwise `r`. Saturates at 2^W−1. Adds no cycles.
  - **Undefined:** `leg_out = r` (floor). The rounding comparator is not synthesised.
  - `err` behaviour is identical in both builds.

## Structure
- Package `pythag_pkg`:
  - FSM state enum (IDLE, MUL_C, MUL_A, SUB, ROOT, DONE).
  - Default `W`.
  - Phase-length constants: MUL_CYC=W, ROOT_CYC=W, total latency constant.
- Sub-module `pythag_isqrt`: sequential 2W-bit → W-bit root engine.
  - Signals: `load`, `step`, `root`, `rem`.
  - Stepped by the parent FSM during ROOT.
  - The multiply phases stay in the parent.

## Test plan
- hyp=5, leg=3, start for one cycle → `busy` for 26 cycles; `done` pulse 25 cycles after accept; `leg_out`=4, `err`=0.
- hyp=255, leg=0 → `leg_out`=255. Then hyp=6, leg=1 (diff 35) → `leg_out`=5 in the floor build, 6 with `PYTHAG_ROUND_EN`.
- hyp=3, leg=5 → `err`=1, `leg_out`=0, latency still 25. A following hyp=13, leg=12 → `leg_out`=5, `err` cleared.
- hyp=10, leg=6, with `ena` dropped for 4 cycles during MUL_A → `done` at 29 cycles, `leg_out`=8. A second `start` pulse while busy is ignored: exactly one `done`.
- `rst` asserted at cycle 12 of an operation → all outputs 0 next cycle, no `done`. A new start with hyp=10, leg=8 → `leg_out`=6.
- `start` held high for 60 cycles with hyp=5, leg=4 → exactly two `done` pulses, 27 cycles apart, each with `leg_out`=3.
